// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds bus widths, LATENCY bounds, the response record and lane selection.
package dmem_pkg;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 4;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
        logic              is_store;
    } rsp_rec_t;

    // Byte loads return the selected lane zero-extended; sign extension is left to the CPU.
    function automatic logic [DATA_W-1:0] lane_extract(input logic [DATA_W-1:0] word,
                                                       input logic              lane,
                                                       input logic              is_byte);
        if (!is_byte)
            return word;
        return (lane == LANE_HI) ? {8'h00, word[15:8]} : {8'h00, word[7:0]};
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response handshake bundle between the CPU data port and the responder.
// master = CPU side, slave = memory responder side.
interface dmem_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_we;
    logic              req_byte;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_addr, req_wdata, req_we, req_byte, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, req_byte, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; storage is not reset.
// The responder guarantees it is never pushed when full or popped when empty.
module dmem_rsp_fifo
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  rsp_rec_t         i_data,
    input  logic             i_pop,
    output rsp_rec_t         o_data,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rsp_rec_t         r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push)
                r_wr <= ptr_inc(r_wr);
            if (i_pop)
                r_rd <= ptr_inc(r_rd);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd];
    assign o_count = r_count;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: in-order fixed-latency load/store service on a 16-bit RAM.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned halfword accesses with rsp_err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2,
    parameter int RSP_DEPTH   = 4
) (
    input  logic  clk,
    input  logic  rst,
    dmem_if.slave bus,
    output logic  busy
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    logic              w_acc;
    logic              w_pop;
    logic              w_err;
    logic              w_wr;
    logic              w_lane;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_word;
    rsp_rec_t          w_rec;
    rsp_rec_t          w_head;
    logic [CNT_W-1:0]  w_fifo_cnt;
    logic [CNT_W-1:0]  w_inflight;
    logic [CNT_W-1:0]  w_outstanding;

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
    logic [LATENCY-1:0] r_vld;
    rsp_rec_t          r_rec [LATENCY];

    // Upper address bits fall away in the cast, so addresses wrap silently.
    assign w_idx  = IDX_W'(bus.req_addr >> 1);
    assign w_lane = bus.req_addr[0];

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_err = !bus.req_byte && (w_lane == LANE_HI);
`else
    assign w_err = 1'b0;
`endif

    assign w_acc  = bus.req_valid && bus.req_ready;
    assign w_wr   = w_acc && bus.req_we && !w_err;
    assign w_word = r_mem[w_idx];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            if (!bus.req_byte)
                r_mem[w_idx] <= bus.req_wdata;
            else if (w_lane == LANE_LO)
                r_mem[w_idx][7:0] <= bus.req_wdata[7:0];
            else
                r_mem[w_idx][15:8] <= bus.req_wdata[7:0];
        end
    end

    always_comb begin
        w_rec.rdata    = (bus.req_we || w_err) ? '0 : lane_extract(w_word, w_lane, bus.req_byte);
        w_rec.err      = w_err;
        w_rec.is_store = bus.req_we;
    end

    // Accept stage -> LATENCY-deep delay line -> response FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_acc;
            for (int i = 1; i < LATENCY; i++)
                r_vld[i] <= r_vld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        r_rec[0] <= w_rec;
        for (int i = 1; i < LATENCY; i++)
            r_rec[i] <= r_rec[i-1];
    end

    dmem_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .CNT_W (CNT_W)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_vld[LATENCY-1]),
        .i_data  (r_rec[LATENCY-1]),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_fifo_cnt)
    );

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < LATENCY; i++)
            w_inflight = w_inflight + CNT_W'(r_vld[i]);
    end

    assign w_outstanding = w_inflight + w_fifo_cnt;
    assign bus.req_ready = (w_outstanding < CNT_W'(RSP_DEPTH)) && !rst;
    assign busy          = (w_outstanding != '0);

    assign bus.rsp_valid = (w_fifo_cnt != '0);
    assign w_pop         = bus.rsp_valid && bus.rsp_ready;
    assign bus.rsp_err   = bus.rsp_valid && w_head.err;
    assign bus.rsp_rdata = (bus.rsp_valid && !w_head.is_store && !w_head.err) ? w_head.rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (LATENCY=2, RSP_DEPTH=4) with an in-order response scoreboard.
// Expected results follow the DMEM_ALIGN_CHECK_EN setting of the build.
module tb_dmem_responder;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    dmem_if bus ();

    dmem_responder #(
        .DEPTH_WORDS (256),
        .LATENCY     (2),
        .RSP_DEPTH   (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request for one edge; scoreboard it only if it was accepted.
    task automatic issue(input logic we, input logic byt, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] er, input logic ee,
                         output logic acc);
        exp_t e;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_byte  = byt;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        acc = bus.req_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            e.rdata = er;
            e.err   = ee;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: the head is checked on the negedge before the edge that consumes it.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
                chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   nacc;

        rst           = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_byte  = 1'b0;
        bus.req_addr  = 16'h0000;
        bus.req_wdata = 16'h0000;
        bus.rsp_ready = 1'b1;
        #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'h0000);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Store then load back to back; responses after T+2 and T+3.
        issue(1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, acc);
        chk("lat_t0_valid", 32'(bus.rsp_valid), 32'd0);
        chk("lat_t0_busy", 32'(busy), 32'd1);
        issue(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, acc);
        chk("lat_t1_valid", 32'(bus.rsp_valid), 32'd0);
        idle();
        chk("lat_t2_valid", 32'(bus.rsp_valid), 32'd1);
        idle();
        chk("lat_t3_valid", 32'(bus.rsp_valid), 32'd1);
        idle();
        chk("lat_t4_valid", 32'(bus.rsp_valid), 32'd0);
        chk("lat_t4_busy", 32'(busy), 32'd0);

        // Byte lanes, issued back to back; the last load wraps 0x0210 onto word 0x08.
        issue(1'b1, 1'b1, 16'h0011, 16'h00AA, 16'h0000, 1'b0, acc);
        issue(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hAAEF, 1'b0, acc);
        issue(1'b0, 1'b1, 16'h0011, 16'h0000, 16'h00AA, 1'b0, acc);
        issue(1'b0, 1'b1, 16'h0010, 16'h0000, 16'h00EF, 1'b0, acc);
        issue(1'b0, 1'b0, 16'h0210, 16'h0000, 16'hAAEF, 1'b0, acc);
        drain();

        // Backpressure: four distinct words, then six loads with rsp_ready low.
        issue(1'b1, 1'b0, 16'h0020, 16'h1111, 16'h0000, 1'b0, acc);
        issue(1'b1, 1'b0, 16'h0022, 16'h2222, 16'h0000, 1'b0, acc);
        issue(1'b1, 1'b0, 16'h0024, 16'h3333, 16'h0000, 1'b0, acc);
        issue(1'b1, 1'b0, 16'h0026, 16'h4444, 16'h0000, 1'b0, acc);
        drain();
        bus.rsp_ready = 1'b0;
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, 1'b0, 16'h0020 + 16'(2 * i), 16'h0000, 16'h1111 * 16'(i + 1), 1'b0, acc);
            if (acc)
                nacc++;
        end
        bus.req_valid = 1'b0;
        chk("bp_accepted", 32'(nacc), 32'd4);
        chk("bp_full_ready", 32'(bus.req_ready), 32'd0);
        repeat (3) idle();
        chk("bp_held_valid", 32'(bus.rsp_valid), 32'd1);
        chk("bp_held_ready", 32'(bus.req_ready), 32'd0);
        chk("bp_held_busy", 32'(busy), 32'd1);
        bus.rsp_ready = 1'b1;
        idle();
        chk("bp_pop1_ready", 32'(bus.req_ready), 32'd1);
        chk("bp_pop1_valid", 32'(bus.rsp_valid), 32'd1);
        idle();
        chk("bp_pop2_valid", 32'(bus.rsp_valid), 32'd1);
        idle();
        chk("bp_pop3_valid", 32'(bus.rsp_valid), 32'd1);
        idle();
        chk("bp_pop4_valid", 32'(bus.rsp_valid), 32'd0);
        chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Misaligned halfword store.
        issue(1'b1, 1'b0, 16'h0012, 16'h5A5A, 16'h0000, 1'b0, acc);
`ifdef DMEM_ALIGN_CHECK_EN
        issue(1'b1, 1'b0, 16'h0013, 16'h1234, 16'h0000, 1'b1, acc);
        issue(1'b0, 1'b0, 16'h0012, 16'h0000, 16'h5A5A, 1'b0, acc);
`else
        issue(1'b1, 1'b0, 16'h0013, 16'h1234, 16'h0000, 1'b0, acc);
        issue(1'b0, 1'b0, 16'h0012, 16'h0000, 16'h1234, 1'b0, acc);
`endif
        drain();

        // Reset mid-flight: three loads are discarded, RAM survives.
        issue(1'b1, 1'b0, 16'h0040, 16'hCAFE, 16'h0000, 1'b0, acc);
        drain();
        bus.rsp_ready = 1'b0;
        issue(1'b0, 1'b0, 16'h0040, 16'h0000, 16'hCAFE, 1'b0, acc);
        issue(1'b0, 1'b0, 16'h0040, 16'h0000, 16'hCAFE, 1'b0, acc);
        issue(1'b0, 1'b0, 16'h0040, 16'h0000, 16'hCAFE, 1'b0, acc);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(bus.req_ready), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (6) idle();
        chk("after_rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("after_rst_busy", 32'(busy), 32'd0);
        issue(1'b0, 1'b0, 16'h0040, 16'h0000, 16'hCAFE, 1'b0, acc);
        drain();
        chk("final_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
